// File: rtl/tcnt_bank.sv
// ---------------------------------------------------------------------------
// tcnt_bank
//
// Purpose:
//   Bank of 2**AW time-multiplexed counters, W bits each, held in a single
//   distributed-RAM array. The entry selected by s is read combinationally on
//   q. When ce is high it is updated by a read-modify-write on the rising edge
//   using one of four operations: write, increment, clear or decrement.
//   Increment and decrement wrap modulo 2**W, or saturate when SAT is set.
//   Overflow and underflow are reported as registered one-cycle pulses.
//   The RAM has no reset. A hardware sweep FSM therefore zeroes every entry
//   after reset, or on request, before normal operation resumes.
//
// Parameters:
//   W    counter width in bits (>= 1)
//   AW   address width, DEPTH = 2**AW entries
//   SAT  0: wrap modulo 2**W, 1: saturate at 0 / all-ones
//
// Ports:
//   c        in   clock, all state changes on the rising edge
//   rn       in   asynchronous active-low reset
//   ce       in   enable for the op applied to entry s
//   clr_all  in   synchronous request to (re)start the clear sweep
//   op       in   00 write d, 01 increment, 10 clear, 11 decrement
//   s        in   entry select (read and write address)
//   d        in   write data for op=00
//   q        out  mem[s], asynchronous read
//   busy     out  high while the clear sweep runs; ops are ignored
//   ovf      out  one-cycle pulse: increment hit an all-ones entry
//   unf      out  one-cycle pulse: decrement hit a zero entry
// ---------------------------------------------------------------------------
module tcnt_bank #(
    parameter int W   = 8,
    parameter int AW  = 6,
    parameter int SAT = 0
) (
    input  logic          c,
    input  logic          rn,
    input  logic          ce,
    input  logic          clr_all,
    input  logic [1:0]    op,
    input  logic [AW-1:0] s,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          ovf,
    output logic          unf
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    localparam logic [W-1:0]  ALL_ONES  = {W{1'b1}};
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        SWEEP,
        RUN
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;

    logic [W-1:0]  mem [DEPTH];

    logic          at_max;
    logic          at_zero;
    logic          op_go;
    logic [W-1:0]  next_val;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [W-1:0]  mem_wd;

    // The read is asynchronous, so back-to-back ops on the same entry always
    // see the value written on the previous edge.
    assign q    = mem[s];
    assign busy = (state == SWEEP);

    // Compute the new value of the selected entry from the q sampled in
    // this cycle. A coincident clr_all request wins and drops the op.
    always_comb begin
        at_max   = (q == ALL_ONES);
        at_zero  = (q == '0);
        op_go    = (state == RUN) && ce && !clr_all;
        next_val = q;
        case (op)
            OP_WRITE: next_val = d;
            OP_CLEAR: next_val = '0;
            OP_INC: begin
                if (at_max) next_val = (SAT != 0) ? ALL_ONES : '0;
                else        next_val = q + W'(1);
            end
            OP_DEC: begin
                if (at_zero) next_val = (SAT != 0) ? '0 : ALL_ONES;
                else         next_val = q - W'(1);
            end
            default: next_val = q;
        endcase
    end

    // The single RAM write port is shared between the sweep and normal ops.
    // Writes are gated with rn so that holding reset leaves the RAM alone.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = s;
        mem_wd = next_val;
        if (state == SWEEP) begin
            mem_we = rn;
            mem_wa = addr;
            mem_wd = '0;
        end else begin
            mem_we = op_go;
        end
    end

    // The RAM array has no reset, so it can map onto distributed RAM.
    always_ff @(posedge c) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Control FSM. SWEEP walks addr from 0 to DEPTH-1, and the last write
    // moves the FSM to RUN. clr_all restarts the sweep from either state.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state <= SWEEP;
            addr  <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            case (state)
                SWEEP: begin
                    if (clr_all) begin
                        addr <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                        if (addr == LAST_ADDR) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (clr_all) begin
                        state <= SWEEP;
                        addr  <= '0;
                    end else if (ce) begin
                        if (op == OP_INC && at_max) ovf <= 1'b1;
                        if (op == OP_DEC && at_zero) unf <= 1'b1;
                    end
                end
                default: begin
                    state <= SWEEP;
                    addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcnt_bank.sv
// ---------------------------------------------------------------------------
// tb_tcnt_bank
//
// Purpose:
//   Drives a wrapping instance (SAT=0) and a saturating instance (SAT=1) of
//   tcnt_bank with the same stimulus. Each cycle, the driver pushes the
//   expected outputs into a scoreboard queue. The expected values come from a
//   behavioural model: an integer array per instance plus a count of sweep
//   cycles still to run. A monitor on the falling edge pops each entry and
//   compares it against both instances.
// ---------------------------------------------------------------------------
module tb_tcnt_bank;

    localparam int W     = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int MAXV  = 255;

    logic          c = 1'b0;
    logic          rn = 1'b0;
    logic          ce = 1'b0;
    logic          clr_all = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [AW-1:0] s = '0;
    logic [W-1:0]  d = '0;

    logic [W-1:0]  q0, q1;
    logic          busy0, busy1, ovf0, ovf1, unf0, unf1;

    tcnt_bank #(.W(W), .AW(AW), .SAT(0)) u_wrap (
        .c(c), .rn(rn), .ce(ce), .clr_all(clr_all), .op(op), .s(s), .d(d),
        .q(q0), .busy(busy0), .ovf(ovf0), .unf(unf0)
    );

    tcnt_bank #(.W(W), .AW(AW), .SAT(1)) u_sat (
        .c(c), .rn(rn), .ce(ce), .clr_all(clr_all), .op(op), .s(s), .d(d),
        .q(q1), .busy(busy1), .ovf(ovf1), .unf(unf1)
    );

    always #5 c = ~c;

    // Reference model state: index 0 is the wrapping bank, index 1 the
    // saturating bank. left_m counts sweep edges still to come.
    int mem_m [2][DEPTH];
    int left_m;
    bit ovf_m [2];
    bit unf_m [2];

    typedef struct {
        bit busy;
        bit ovf0;
        bit ovf1;
        bit unf0;
        bit unf1;
        bit qv;
        int q0;
        int q1;
    } exp_t;

    exp_t sb [$];

    int checks = 0;
    int passes = 0;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Snapshot what both banks should show during the current cycle.
    task automatic pushExpect();
        exp_t e;
        e.busy = (left_m > 0);
        e.ovf0 = ovf_m[0];
        e.ovf1 = ovf_m[1];
        e.unf0 = unf_m[0];
        e.unf1 = unf_m[1];
        e.qv   = !e.busy;
        e.q0   = mem_m[0][s];
        e.q1   = mem_m[1][s];
        sb.push_back(e);
    endtask

    // Advance the model across the upcoming rising edge using the inputs
    // currently applied.
    task automatic modelStep();
        int v;
        for (int i = 0; i < 2; i++) begin
            ovf_m[i] = 1'b0;
            unf_m[i] = 1'b0;
        end
        if (left_m > 0) begin
            if (clr_all) begin
                left_m = DEPTH;
            end else begin
                left_m--;
                if (left_m == 0) begin
                    for (int i = 0; i < 2; i++)
                        for (int a = 0; a < DEPTH; a++) mem_m[i][a] = 0;
                end
            end
        end else if (clr_all) begin
            left_m = DEPTH;
        end else if (ce) begin
            for (int i = 0; i < 2; i++) begin
                v = mem_m[i][s];
                case (op)
                    2'b00: v = int'(d);
                    2'b10: v = 0;
                    2'b01: begin
                        if (v == MAXV) begin
                            ovf_m[i] = 1'b1;
                            v = (i == 1) ? MAXV : 0;
                        end else v = v + 1;
                    end
                    default: begin
                        if (v == 0) begin
                            unf_m[i] = 1'b1;
                            v = (i == 1) ? 0 : MAXV;
                        end else v = v - 1;
                    end
                endcase
                mem_m[i][s] = v;
            end
        end
    endtask

    // Apply one cycle of inputs, record the expectation, then step the model.
    task automatic applyStimulus(input bit ce_i, input logic [1:0] op_i,
                                 input int s_i, input int d_i, input bit clr_i);
        @(posedge c);
        #1;
        ce      = ce_i;
        op      = op_i;
        s       = AW'(s_i);
        d       = W'(d_i);
        clr_all = clr_i;
        pushExpect();
        modelStep();
    endtask

    // Hold reset for a few cycles, then release it so the next edge is the
    // first sweep edge.
    task automatic applyReset();
        @(posedge c);
        #1;
        rn      = 1'b0;
        ce      = 1'b0;
        clr_all = 1'b0;
        left_m  = DEPTH;
        for (int i = 0; i < 2; i++) begin
            ovf_m[i] = 1'b0;
            unf_m[i] = 1'b0;
        end
        pushExpect();
        repeat (2) begin
            @(posedge c);
            #1;
            pushExpect();
        end
        rn = 1'b1;
        modelStep();
    endtask

    // Monitor: pops one expectation per cycle and checks both instances.
    always @(negedge c) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("busy_wrap", 32'(busy0), 32'(e.busy));
            checkOutput("busy_sat",  32'(busy1), 32'(e.busy));
            checkOutput("ovf_wrap",  32'(ovf0),  32'(e.ovf0));
            checkOutput("ovf_sat",   32'(ovf1),  32'(e.ovf1));
            checkOutput("unf_wrap",  32'(unf0),  32'(e.unf0));
            checkOutput("unf_sat",   32'(unf1),  32'(e.unf1));
            if (e.qv) begin
                checkOutput("q_wrap", 32'(q0), e.q0);
                checkOutput("q_sat",  32'(q1), e.q1);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int rd;
        left_m = DEPTH;
        for (int i = 0; i < 2; i++) begin
            ovf_m[i] = 1'b0;
            unf_m[i] = 1'b0;
            for (int a = 0; a < DEPTH; a++) mem_m[i][a] = 0;
        end

        // Sweep after reset while ce=1 and op=inc are held throughout.
        $display("[TB] reset sweep with inc held");
        applyReset();
        for (int k = 0; k < DEPTH + 2; k++) applyStimulus(1'b1, 2'b01, k % DEPTH, 0, 1'b0);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, 2'b01, a, 0, 1'b0);

        // Write near the top, then increment through the all-ones boundary.
        $display("[TB] increment across all-ones");
        applyStimulus(1'b1, 2'b00, 5, 8'hFE, 1'b0);
        applyStimulus(1'b1, 2'b01, 5, 0, 1'b0);
        applyStimulus(1'b1, 2'b01, 5, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 5, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 5, 0, 1'b0);

        // Write one, then decrement three times through zero.
        $display("[TB] decrement across zero");
        applyStimulus(1'b1, 2'b00, 3, 8'h01, 1'b0);
        repeat (3) applyStimulus(1'b1, 2'b11, 3, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 3, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 3, 0, 1'b0);

        // With ce=0 the entry must not change, and a write to a neighbour
        // must leave it alone.
        $display("[TB] ce gating and neighbour isolation");
        applyStimulus(1'b1, 2'b00, 7, 8'h55, 1'b0);
        applyStimulus(1'b0, 2'b10, 7, 0, 1'b0);
        applyStimulus(1'b0, 2'b10, 7, 0, 1'b0);
        applyStimulus(1'b1, 2'b00, 8, 8'hAA, 1'b0);
        applyStimulus(1'b0, 2'b00, 7, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 8, 0, 1'b0);

        // clr_all coincident with a write: the write is dropped and the
        // sweep runs.
        $display("[TB] clr_all with coincident write");
        applyStimulus(1'b1, 2'b00, 2, 8'h11, 1'b0);
        applyStimulus(1'b1, 2'b00, 2, 8'hAA, 1'b1);
        for (int k = 0; k < DEPTH + 1; k++) applyStimulus(1'b1, 2'b00, 2, 8'hAA, 1'b0);
        applyStimulus(1'b0, 2'b00, 2, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 7, 0, 1'b0);

        // Reset mid-sweep at addr 30, then require a full sweep.
        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, 2'b00, 9, 8'h33, 1'b1);
        for (int k = 0; k < 30; k++) applyStimulus(1'b1, 2'b01, 9, 0, 1'b0);
        applyReset();
        for (int k = 0; k < DEPTH + 1; k++) applyStimulus(1'b0, 2'b00, k % DEPTH, 0, 1'b0);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, 2'b00, a, 0, 1'b0);

        // Random ops on a small address window so entries are revisited,
        // with data biased towards the 0 and all-ones boundaries.
        $display("[TB] random traffic");
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 3);
            rd = (r == 0) ? 0 : (r == 1) ? MAXV : (r == 2) ? 1 : int'($urandom_range(0, MAXV));
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), rd, ($urandom_range(0, 149) == 0));
        end

        // Give the monitor time to drain the queue.
        @(posedge c);
        @(negedge c);
        #1;
        if (sb.size() != 0) checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
